seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_shift_reg.sv | 26 ++
 rtl/seq_pattern_tx.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM state encoding and default pattern for the sequence blocks
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } seq_state_e;

   localparam logic [4:0] SEQ_PAT_DEF = 5'b10110;

   // Rotate left by one so the MSB wraps to the LSB position
   function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned w);
      logic [15:0] r;
      r = '0;
      for (int i = 1; i < 16; i++) if (i < w) r[i] = v[i-1];
      r[0] = v[w-1];
      return r;
   endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: loadable MSB-first rotating shift register holding the captured pattern
module seq_shift_reg #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] d_i,
   output logic         msb_o
);

   logic [W-1:0] sr_q;
   logic [W-1:0] sr_d;

   // Load wins over shift; shifting rotates so the pattern is restored after W shifts
   always_comb sr_d = load_i ? d_i : shift_i ? {sr_q[W-2:0], sr_q[W-1]} : sr_q;

   // Pattern storage, cleared on reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= '0;
      else sr_q <= sr_d;

   assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeats a captured bit pattern MSB first, with optional idle gaps between repetitions
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int unsigned      PAT_W   = 5,
   parameter logic [PAT_W-1:0] PAT_DEF = SEQ_PAT_DEF,
   parameter int unsigned      GAP_CYC = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             use_def_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [3:0]       rpt_i,
   input  logic             abort_i,
   output logic             ready_o,
   output logic             out_o,
   output logic             out_valid_o,
   output logic             sof_o,
   output logic             done_o
);

   localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
   localparam logic [3:0]       GAP_TOP = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       rep_q, rep_d;
   logic [3:0]       gap_q, gap_d;
   logic             out_q, out_d;
   logic             vld_q, vld_d;
   logic             sof_q, sof_d;
   logic             done_q, done_d;
   logic             load, shift, sr_msb;
   logic [PAT_W-1:0] sel_pat, load_val;

   assign sel_pat  = use_def_i ? PAT_DEF : pattern_i;
   // The MSB goes straight to out at capture, so the register starts one rotation ahead
   assign load_val = {sel_pat[PAT_W-2:0], sel_pat[PAT_W-1]};

   seq_shift_reg #(.W(PAT_W)) u_sr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .shift_i (shift),
      .d_i     (load_val),
      .msb_o   (sr_msb)
   );

   // Next-state and next-output logic; idx_q is the index of the bit currently on out
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      out_d   = 1'b0;
      vld_d   = 1'b0;
      sof_d   = 1'b0;
      done_d  = 1'b0;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_d = SEND;
               load    = 1'b1;
               idx_d   = IDX_TOP;
               rep_d   = rpt_i;
               gap_d   = '0;
               out_d   = sel_pat[PAT_W-1];
               vld_d   = 1'b1;
               sof_d   = 1'b1;
            end
         end
         SEND: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (idx_q != '0) begin
               idx_d = idx_q - 1'b1;
               out_d = sr_msb;
               vld_d = 1'b1;
               shift = 1'b1;
            end else if (rep_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               rep_d = rep_q - 1'b1;
               if (GAP_CYC == 0) begin
                  idx_d = IDX_TOP;
                  out_d = sr_msb;
                  vld_d = 1'b1;
                  sof_d = 1'b1;
                  shift = 1'b1;
               end else begin
                  state_d = GAP;
                  gap_d   = GAP_TOP;
               end
            end
         end
         GAP: begin
            if (abort_i) begin
               state_d = IDLE;
            end else if (gap_q == '0) begin
               state_d = SEND;
               idx_d   = IDX_TOP;
               out_d   = sr_msb;
               vld_d   = 1'b1;
               sof_d   = 1'b1;
               shift   = 1'b1;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         out_q   <= 1'b0;
         vld_q   <= 1'b0;
         sof_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         out_q   <= out_d;
         vld_q   <= vld_d;
         sof_q   <= sof_d;
         done_q  <= done_d;
      end

   assign ready_o     = (state_q == IDLE);
   assign out_o       = out_q;
   assign out_valid_o = vld_q;
   assign sof_o       = sof_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed vectors plus randomized traffic against a frame-level model
module tb_seq_pattern_tx;

   typedef logic [4:0] ent_t;
   typedef ent_t ent_q_t[$];
   typedef struct {
      logic       start;
      logic       use_def;
      logic       abort;
      logic [4:0] pat;
      logic [3:0] rpt;
      ent_t       exp;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, use_def = 1'b0, abort = 1'b0;
   logic [4:0] pat = '0;
   logic [3:0] rpt = '0;
   logic rdy0, out0, vld0, sof0, done0;
   logic rdy2, out2, vld2, sof2, done2;
   int checks = 0, failures = 0;
   ent_q_t q0, q2;
   ent_t cur0 = 5'b10000, cur2 = 5'b10000;
   vec_t vt[$];

   always #5 clk = ~clk;

   seq_pattern_tx #(.PAT_W(5), .GAP_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(start), .use_def_i(use_def), .pattern_i(pat),
      .rpt_i(rpt), .abort_i(abort), .ready_o(rdy0), .out_o(out0), .out_valid_o(vld0),
      .sof_o(sof0), .done_o(done0)
   );

   seq_pattern_tx #(.PAT_W(5), .GAP_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(start), .use_def_i(use_def), .pattern_i(pat),
      .rpt_i(rpt), .abort_i(abort), .ready_o(rdy2), .out_o(out2), .out_valid_o(vld2),
      .sof_o(sof2), .done_o(done2)
   );

   // Expected per-cycle trace {ready,out,valid,sof,done} of one whole frame
   function automatic ent_q_t frame(input logic [4:0] p, input int r, input int gap);
      ent_q_t q;
      for (int k = 0; k <= r; k++) begin
         for (int b = 4; b >= 0; b--) q.push_back({1'b0, p[b], 1'b1, (b == 4), 1'b0});
         if (k < r) for (int g = 0; g < gap; g++) q.push_back(5'b00000);
      end
      q.push_back(5'b10001);
      return q;
   endfunction

   function automatic ent_t d0o();
      return {rdy0, out0, vld0, sof0, done0};
   endfunction

   function automatic ent_t d2o();
      return {rdy2, out2, vld2, sof2, done2};
   endfunction

   function automatic vec_t v(input logic s, ud, ab, input logic [4:0] p, input logic [3:0] r, input ent_t e);
      vec_t x;
      x.start = s; x.use_def = ud; x.abort = ab; x.pat = p; x.rpt = r; x.exp = e;
      return x;
   endfunction

   task automatic chk(input string n, input ent_t act, input ent_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got={rdy,out,vld,sof,done}=%b want=%b", n, $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then compare both DUTs
   task automatic step(input logic s, ud, ab, input logic [4:0] p, input logic [3:0] r);
      logic [4:0] psel;
      start = s; use_def = ud; abort = ab; pat = p; rpt = r;
      @(posedge clk);
      psel = ud ? 5'b10110 : p;
      if (cur0[4] && s && !ab) q0 = frame(psel, int'(r), 0);
      else if (!cur0[4] && ab) q0.delete();
      if (cur2[4] && s && !ab) q2 = frame(psel, int'(r), 2);
      else if (!cur2[4] && ab) q2.delete();
      cur0 = (q0.size() > 0) ? q0.pop_front() : 5'b10000;
      cur2 = (q2.size() > 0) ? q2.pop_front() : 5'b10000;
      #1;
      chk("model_gap0", d0o(), cur0);
      chk("model_gap2", d2o(), cur2);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
   endtask

   initial begin
      logic [14:0] bits34;
      logic [4:0]  p35;
      ent_t        e;
      bits34 = 15'b101101011010110;
      p35    = 5'b11001;
      #2;
      chk("reset_gap0", d0o(), 5'b10000);
      chk("reset_gap2", d2o(), 5'b10000);
      #10 rst_n = 1'b1;

      // default frame, abort, abort+start, start re-pulse, back-to-back
      vt.push_back(v(1,1,0,5'd0,4'd0,5'b01110));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10001));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10000));
      vt.push_back(v(1,1,0,5'd0,4'd0,5'b01110));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,1,5'd0,4'd0,5'b10000));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10000));
      vt.push_back(v(1,1,1,5'd0,4'd0,5'b10000));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10000));
      vt.push_back(v(1,0,0,5'b11001,4'd0,5'b01110));
      vt.push_back(v(1,1,0,5'd0,4'd5,5'b01100));
      vt.push_back(v(1,1,0,5'd0,4'd5,5'b00100));
      vt.push_back(v(1,1,0,5'd0,4'd5,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10001));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10000));
      vt.push_back(v(1,0,0,5'b00011,4'd0,5'b00110));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10001));
      vt.push_back(v(1,1,0,5'd0,4'd0,5'b01110));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b01100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b00100));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10001));
      vt.push_back(v(0,0,0,5'd0,4'd0,5'b10000));
      foreach (vt[i]) begin
         step(vt[i].start, vt[i].use_def, vt[i].abort, vt[i].pat, vt[i].rpt);
         chk($sformatf("vec%0d", i), d0o(), vt[i].exp);
      end

      // three contiguous default repetitions without a gap
      for (int c = 1; c <= 16; c++) begin
         if (c == 1) step(1'b1, 1'b1, 1'b0, 5'd0, 4'd2);
         else idle(1);
         e = (c <= 15) ? {1'b0, bits34[15-c], 1'b1, (c % 5 == 1), 1'b0} : 5'b10001;
         chk($sformatf("rpt2_c%0d", c), d0o(), e);
      end
      idle(8);

      // two user-pattern repetitions separated by a two-cycle gap
      for (int c = 1; c <= 13; c++) begin
         if (c == 1) step(1'b1, 1'b0, 1'b0, p35, 4'd1);
         else idle(1);
         if (c <= 5) e = {1'b0, p35[5-c], 1'b1, (c == 1), 1'b0};
         else if (c <= 7) e = 5'b00000;
         else if (c <= 12) e = {1'b0, p35[12-c], 1'b1, (c == 8), 1'b0};
         else e = 5'b10001;
         chk($sformatf("gap2_c%0d", c), d2o(), e);
      end
      idle(2);

      // asynchronous reset in the middle of a long frame
      step(1'b1, 1'b1, 1'b0, 5'd0, 4'd3);
      idle(2);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_async_gap0", d0o(), 5'b10000);
      chk("rst_async_gap2", d2o(), 5'b10000);
      q0.delete(); q2.delete();
      cur0 = 5'b10000; cur2 = 5'b10000;
      @(posedge clk); #1;
      chk("rst_hold_gap0", d0o(), 5'b10000);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 5'd0, 4'd0);
      chk("post_rst_msb", d0o(), 5'b01110);
      idle(6);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] r;
         r = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
         step($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 24) == 0, 5'($urandom), r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
